arbitro_compuerta: RTL
======================

ARBITRO_COMPUERTA -- requirements
Module: arbitro_compuerta

Interface
REQ-001 Parameter PIN_CORRECTO, default 8'h08, the entry PIN that opens the gate.
REQ-002 Parameter MAX_INTENTOS, default 3, the number of wrong PINs that raise the alarm.
REQ-003 Parameter T_ABIERTO, default 16, the clock cycles the gate stays open without Termino.
REQ-004 Clk  input  1  the single clock; all state changes on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Vehiculo_ent  input  1  vehicle present at the entry lane.
REQ-007 Vehiculo_sal  input  1  vehicle present at the exit lane; no PIN is required.
REQ-008 Pin  input  8  entry keypad; 8'h00 means idle, non-zero means a PIN is presented.
REQ-009 Termino  input  1  vehicle has fully crossed the gate.
REQ-010 Abierto / Cerrado  output  1 each  gate open / gate closed; always complementary.
REQ-011 Concede_ent / Concede_sal  output  1 each  lane currently granted the gate; one-hot or zero.
REQ-012 Alarma / Bloqueo  output  1 each  wrong-PIN alarm / tailgating lockout.

Function
REQ-013 States SHALL be: CERRADO, ESPERA_PIN, ABIERTO_ENT, ABIERTO_SAL, ALARMA, BLOQUEO; all outputs SHALL be registered and decoded from the state.
REQ-014 A PIN attempt is the single cycle where Pin != 0 and the registered previous Pin == 0; a held Pin SHALL count once.
REQ-015 CERRADO: Vehiculo_sal alone -> ABIERTO_SAL; Vehiculo_ent alone -> ESPERA_PIN; both asserted -> the lane not served last wins (one-bit round-robin, exit wins first after reset).
REQ-016 ESPERA_PIN: attempt == PIN_CORRECTO -> ABIERTO_ENT and clear the wrong-attempt counter; wrong attempt -> increment the counter and stay; Vehiculo_ent low -> CERRADO with the counter kept.
REQ-017 When the counter reaches MAX_INTENTOS -> ALARMA; Alarma=1 and the gate stays closed.
REQ-018 ALARMA: only a correct attempt exits -> CERRADO, and it clears the counter; wrong attempts SHALL keep Alarma=1 without wrapping the counter (saturating 2-bit counter).
REQ-019 ABIERTO_ENT / ABIERTO_SAL: Termino -> CERRADO and record the served lane.
REQ-020 In ABIERTO_ENT and ABIERTO_SAL, an 8-bit timer counts from entry; at T_ABIERTO-1 with no Termino -> CERRADO, and the lane is recorded as served.
REQ-021 In ABIERTO_ENT, Termino and Vehiculo_ent both high in the same cycle (tailgating) -> BLOQUEO; Bloqueo=1, gate closed.
REQ-022 BLOQUEO: only a correct attempt exits -> CERRADO; Alarma SHALL stay 0 in BLOQUEO, and wrong attempts SHALL NOT increment the counter.
REQ-023 Requests arriving while the gate is open SHALL wait; they are not queued beyond the level of their inputs.
REQ-024 Gate latency: the grant and Abierto SHALL rise on the first rising edge after the qualifying input is sampled.

Reset
REQ-025 Reset low SHALL immediately force: state CERRADO, Cerrado=1, Abierto=0, both grants 0, Alarma=0, Bloqueo=0, counter=0, timer=0, previous Pin=0, round-robin pointer=exit.
REQ-026 Reset mid-operation (gate open, alarm or lockout) SHALL abandon it with no memory; operation resumes on the first edge after Reset returns high.

Structure
REQ-027 A shared package SHALL hold the state encoding, the 8'h00 idle-PIN constant and the parameter defaults.
REQ-028 One sub-module, contador_intentos, SHALL contain the PIN edge detection, the comparison and the saturating wrong-attempt counter.

Verification
REQ-029 Vehiculo_ent=1, Pin=8'h08 for 2 cycles -> one attempt, Abierto=1, Concede_ent=1; Termino=1 -> Cerrado=1 on the next edge.
REQ-030 Pin=8'h01 three times, each separated by 8'h00 -> Alarma=1 after the third; Pin=8'h08 -> Alarma=0, Cerrado=1.
REQ-031 Vehiculo_ent and Vehiculo_sal rise together after reset -> Concede_sal first; after Termino, Concede_ent (ESPERA_PIN) next.
REQ-032 Entry opened, then Termino=1 while Vehiculo_ent=1 -> Bloqueo=1; Pin=8'h01 -> Bloqueo still 1 and the counter stays 0; Pin=8'h08 -> Bloqueo=0.
REQ-033 Exit opened, no Termino for 16 cycles -> Cerrado=1 exactly at cycle 16.
REQ-034 Reset pulsed low while in ALARMA -> all outputs are at their reset values asynchronously; the next wrong PIN gives counter=1, not an alarm.

Source files
------------

// File: rtl/arbitro_compuerta_pkg.sv
// Shared definitions for the gate arbiter: FSM state encoding, the idle-keypad
// constant and the default values of the arbiter parameters.
package arbitro_compuerta_pkg;

  typedef enum logic [2:0] {
    StCerrado    = 3'd0,
    StEsperaPin  = 3'd1,
    StAbiertoEnt = 3'd2,
    StAbiertoSal = 3'd3,
    StAlarma     = 3'd4,
    StBloqueo    = 3'd5
  } estado_t;

  // Keypad value meaning "no PIN presented".
  localparam logic [7:0]  PinInactivo    = 8'h00;

  localparam logic [7:0]  PinCorrectoDef = 8'h08;
  localparam int unsigned MaxIntentosDef = 3;
  localparam int unsigned TAbiertoDef    = 16;

endpackage

// File: rtl/arbitro_compuerta_if.sv
// Lane/keypad/gate signal bundle for the gate arbiter.
//   master : drives vehicle sensors, keypad and Termino; observes gate status.
//   slave  : the arbiter side.
interface arbitro_compuerta_if;
  logic       Vehiculo_ent;
  logic       Vehiculo_sal;
  logic [7:0] Pin;
  logic       Termino;
  logic       Abierto;
  logic       Cerrado;
  logic       Concede_ent;
  logic       Concede_sal;
  logic       Alarma;
  logic       Bloqueo;

  modport master (
    output Vehiculo_ent, Vehiculo_sal, Pin, Termino,
    input  Abierto, Cerrado, Concede_ent, Concede_sal, Alarma, Bloqueo
  );

  modport slave (
    input  Vehiculo_ent, Vehiculo_sal, Pin, Termino,
    output Abierto, Cerrado, Concede_ent, Concede_sal, Alarma, Bloqueo
  );
endinterface

// File: rtl/contador_intentos.sv
// PIN attempt detector and saturating wrong-attempt counter.
//   Clk, Reset : clock, asynchronous active-low reset
//   pin        : keypad value (PinInactivo = idle)
//   cuenta_en  : wrong attempts are counted only while high
//   borrar     : clear the counter (wins over counting)
//   pin_ok     : this cycle is an attempt and matches PIN_CORRECTO
//   pin_mal    : this cycle is an attempt and does not match
//   limite     : wrong attempt that brings the counter to MAX_INTENTOS
module contador_intentos
  import arbitro_compuerta_pkg::*;
#(
  parameter logic [7:0]  PIN_CORRECTO = PinCorrectoDef,
  parameter int unsigned MAX_INTENTOS = MaxIntentosDef
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] pin,
  input  logic       cuenta_en,
  input  logic       borrar,
  output logic       pin_ok,
  output logic       pin_mal,
  output logic       limite
);

  logic       pin_activo_q;
  logic [1:0] cnt_q, cnt_d;
  logic       intento;

  // An attempt is the first cycle of a non-idle keypad value; holding counts once.
  assign intento = (pin != PinInactivo) && !pin_activo_q;
  assign pin_ok  = intento && (pin == PIN_CORRECTO);
  assign pin_mal = intento && (pin != PIN_CORRECTO);
  assign limite  = pin_mal && ((32'(cnt_q) + 32'd1) >= MAX_INTENTOS);

  always_comb begin
    cnt_d = cnt_q;
    if (borrar) begin
      cnt_d = 2'd0;
    end else if (cuenta_en && pin_mal && (cnt_q != 2'd3)) begin
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pin_activo_q <= 1'b0;
      cnt_q        <= 2'd0;
    end else begin
      pin_activo_q <= (pin != PinInactivo);
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: rtl/arbitro_compuerta.sv
// Parking gate arbiter: serves an entry lane (PIN protected) and an exit lane,
// with open-time limit, wrong-PIN alarm and tailgating lockout.
//   Clk, Reset : clock, asynchronous active-low reset
//   bus        : lane sensors, keypad, Termino in; gate status and grants out
// All outputs are registered from the next state.
module arbitro_compuerta
  import arbitro_compuerta_pkg::*;
#(
  parameter logic [7:0]  PIN_CORRECTO = PinCorrectoDef,
  parameter int unsigned MAX_INTENTOS = MaxIntentosDef,
  parameter int unsigned T_ABIERTO    = TAbiertoDef
) (
  input logic              Clk,
  input logic              Reset,
  arbitro_compuerta_if.slave bus
);

  estado_t    estado_q, estado_d;
  logic [7:0] timer_q, timer_d;
  logic       rr_sal_q, rr_sal_d;  // 1: exit lane has priority on a tie
  logic       cuenta_en, borrar;
  logic       pin_ok, pin_mal, limite;
  logic       fin_timer;
  logic       abierto_q, concede_ent_q, concede_sal_q, alarma_q, bloqueo_q;

  contador_intentos #(
    .PIN_CORRECTO (PIN_CORRECTO),
    .MAX_INTENTOS (MAX_INTENTOS)
  ) u_contador (
    .Clk       (Clk),
    .Reset     (Reset),
    .pin       (bus.Pin),
    .cuenta_en (cuenta_en),
    .borrar    (borrar),
    .pin_ok    (pin_ok),
    .pin_mal   (pin_mal),
    .limite    (limite)
  );

  assign fin_timer = (timer_q == 8'(T_ABIERTO - 1));

  always_comb begin
    estado_d  = estado_q;
    rr_sal_d  = rr_sal_q;
    cuenta_en = 1'b0;
    borrar    = 1'b0;
    unique case (estado_q)
      StCerrado: begin
        if (bus.Vehiculo_sal && bus.Vehiculo_ent) begin
          estado_d = rr_sal_q ? StAbiertoSal : StEsperaPin;
        end else if (bus.Vehiculo_sal) begin
          estado_d = StAbiertoSal;
        end else if (bus.Vehiculo_ent) begin
          estado_d = StEsperaPin;
        end
      end
      StEsperaPin: begin
        if (!bus.Vehiculo_ent) begin
          estado_d = StCerrado;  // counter kept across departures
        end else begin
          cuenta_en = 1'b1;
          if (pin_ok) begin
            borrar   = 1'b1;
            estado_d = StAbiertoEnt;
          end else if (limite) begin
            estado_d = StAlarma;
          end
        end
      end
      StAbiertoEnt: begin
        if (bus.Termino && bus.Vehiculo_ent) begin
          estado_d = StBloqueo;  // another car followed the served one
        end else if (bus.Termino || fin_timer) begin
          estado_d = StCerrado;
          rr_sal_d = 1'b1;
        end
      end
      StAbiertoSal: begin
        if (bus.Termino || fin_timer) begin
          estado_d = StCerrado;
          rr_sal_d = 1'b0;
        end
      end
      StAlarma: begin
        cuenta_en = 1'b1;  // saturates, so further wrong PINs are harmless
        if (pin_ok) begin
          borrar   = 1'b1;
          estado_d = StCerrado;
        end
      end
      StBloqueo: begin
        if (pin_ok) begin
          estado_d = StCerrado;
        end
      end
      default: estado_d = StCerrado;
    endcase
  end

  // Timer runs only while staying in an open state; restarts at 0 on entry.
  always_comb begin
    timer_d = 8'd0;
    if ((estado_d == estado_q) &&
        ((estado_q == StAbiertoEnt) || (estado_q == StAbiertoSal))) begin
      timer_d = timer_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      estado_q      <= StCerrado;
      timer_q       <= 8'd0;
      rr_sal_q      <= 1'b1;
      abierto_q     <= 1'b0;
      concede_ent_q <= 1'b0;
      concede_sal_q <= 1'b0;
      alarma_q      <= 1'b0;
      bloqueo_q     <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      timer_q       <= timer_d;
      rr_sal_q      <= rr_sal_d;
      abierto_q     <= (estado_d == StAbiertoEnt) || (estado_d == StAbiertoSal);
      concede_ent_q <= (estado_d == StEsperaPin) || (estado_d == StAbiertoEnt);
      concede_sal_q <= (estado_d == StAbiertoSal);
      alarma_q      <= (estado_d == StAlarma);
      bloqueo_q     <= (estado_d == StBloqueo);
    end
  end

  assign bus.Abierto     = abierto_q;
  assign bus.Cerrado     = !abierto_q;
  assign bus.Concede_ent = concede_ent_q;
  assign bus.Concede_sal = concede_sal_q;
  assign bus.Alarma      = alarma_q;
  assign bus.Bloqueo     = bloqueo_q;

  // pin_mal is consumed inside the counter; kept visible for debug.
  logic unused_pin_mal;
  assign unused_pin_mal = pin_mal;

endmodule
